// File: rtl/linelength_pkg.sv
// Shared types and helpers for the windowed line-length extractor.
// Widths here are upper bounds; each instance narrows them to its own parameters.
package linelength_pkg;

    localparam int MAX_DW = 64;
    localparam int PTR_W  = 8;
    localparam int CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic             primed;
        logic [CNT_W-1:0] count;
        logic [PTR_W-1:0] ptr;
    } ch_state_t;

    // Sum never saturates: WIN differences of at most 2^DW-1 each.
    function automatic int sum_width(input int dw, input int win);
        return dw + 1 + $clog2(win);
    endfunction

    // Operands are sign-extended DW-bit samples, so the difference cannot wrap.
    function automatic logic [MAX_DW:0] abs_diff(input logic signed [MAX_DW:0] a,
                                                 input logic signed [MAX_DW:0] b);
        logic signed [MAX_DW:0] diff;
        diff = a - b;
        if (diff < 0)
            return -diff;
        return diff;
    endfunction

endpackage

// File: rtl/linelength_win_if.sv
// Sample-in / result-out bundle for linelength_win, including the synchronous clear.
interface linelength_win_if
    import linelength_pkg::*;
#(
    parameter int DW  = 32,
    parameter int CH  = 4,
    parameter int WIN = 16
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int SW = sum_width(DW, WIN);

    logic          clr;
    logic          in_valid;
    logic [CW-1:0] in_ch;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [CW-1:0] out_ch;
    logic [SW-1:0] out_sum;
    logic          out_full;

    modport master (
        output clr, in_valid, in_ch, in_data,
        input  out_valid, out_ch, out_sum, out_full
    );

    modport slave (
        input  clr, in_valid, in_ch, in_data,
        output out_valid, out_ch, out_sum, out_full
    );

endinterface

// File: rtl/ll_ring.sv
// Per-channel ring of absolute differences; one shared memory addressed {ch, ptr}.
// Read and write hit the same slot; the registered read returns the value being overwritten.
module ll_ring #(
    parameter int DW = 32,
    parameter int CH = 4,
    parameter int CW = 2,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          en,
    input  logic [CW-1:0] ch,
    input  logic [PW-1:0] ptr,
    input  logic [DW:0]   wr_data,
    output logic [DW:0]   rd_data
);

    logic [DW:0] mem [CH << PW];

    always_ff @(posedge clk) begin
        if (en) begin
            rd_data        <= mem[{ch, ptr}];
            mem[{ch, ptr}] <= wr_data;
        end
    end

endmodule

// File: rtl/linelength_win.sv
// Windowed line length over CH time-multiplexed channels: sum of the last WIN |dx|.
// prev/ptr/count commit at the accepting edge and sum commits in S2, so same-channel back-to-back needs no bypass.
module linelength_win
    import linelength_pkg::*;
#(
    parameter int DW  = 32,
    parameter int CH  = 4,
    parameter int WIN = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    linelength_win_if.slave bus
);

    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int PW = $clog2(WIN);
    localparam int SW = sum_width(DW, WIN);
    localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WIN);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WIN - 1);

    function automatic logic signed [MAX_DW:0] sext(input logic [DW-1:0] v);
        return {{(MAX_DW + 1 - DW){v[DW-1]}}, v};
    endfunction

    ch_state_t     st_q   [CH];
    logic [DW-1:0] prev_q [CH];
    logic [SW-1:0] sum_q  [CH];

    logic          ch_ok;
    logic          accept;
    logic          diff_ok;
    ch_state_t     cur;
    ch_state_t     cur_nx;
    logic [DW-1:0] prev_cur;
    logic [DW:0]   d_c;

    logic          s1_valid;
    logic [CW-1:0] s1_ch;
    logic [DW:0]   s1_d;
    logic          s1_evict;
    logic          s1_full;
    logic [DW:0]   ring_old;
    logic [DW:0]   oldest;
    logic [SW-1:0] sum_nx;

    logic          out_valid_q;
    logic [CW-1:0] out_ch_q;
    logic [SW-1:0] out_sum_q;
    logic          out_full_q;

    generate
        if (CH == (1 << CW)) begin : g_all_ch
            assign ch_ok = 1'b1;
        end else begin : g_part_ch
            assign ch_ok = (bus.in_ch < CW'(CH));
        end
    endgenerate

    assign accept   = bus.in_valid && ch_ok && !bus.clr;
    assign cur      = st_q[bus.in_ch];
    assign prev_cur = prev_q[bus.in_ch];
    assign diff_ok  = accept && cur.primed;
    assign d_c      = (DW + 1)'(abs_diff(sext(bus.in_data), sext(prev_cur)));

    always_comb begin
        cur_nx        = cur;
        cur_nx.primed = 1'b1;
        if (cur.primed) begin
            cur_nx.count = (cur.count == WIN_CNT) ? cur.count : cur.count + CNT_W'(1);
            cur_nx.ptr   = (cur.ptr == PTR_LAST) ? '0 : cur.ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                st_q[i]   <= '0;
                prev_q[i] <= '0;
            end
        end else if (bus.clr) begin
            for (int i = 0; i < CH; i++) begin
                st_q[i]   <= '0;
                prev_q[i] <= '0;
            end
        end else if (accept) begin
            st_q[bus.in_ch]   <= cur_nx;
            prev_q[bus.in_ch] <= bus.in_data;
        end
    end

    ll_ring #(
        .DW (DW),
        .CH (CH),
        .CW (CW),
        .PW (PW)
    ) u_ring (
        .clk     (clk),
        .en      (diff_ok),
        .ch      (bus.in_ch),
        .ptr     (cur.ptr[PW-1:0]),
        .wr_data (d_c),
        .rd_data (ring_old)
    );

    // S1: channel, difference and whether the slot being overwritten leaves the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_d     <= '0;
            s1_evict <= 1'b0;
            s1_full  <= 1'b0;
        end else if (bus.clr) begin
            s1_valid <= 1'b0;
            s1_evict <= 1'b0;
        end else begin
            s1_valid <= diff_ok;
            if (diff_ok) begin
                s1_ch    <= bus.in_ch;
                s1_d     <= d_c;
                s1_evict <= (cur.count == WIN_CNT);
                s1_full  <= (cur_nx.count == WIN_CNT);
            end
        end
    end

    assign oldest = s1_evict ? ring_old : '0;
    assign sum_nx = sum_q[s1_ch] + SW'(s1_d) - SW'(oldest);

    // S2: running sum update and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++)
                sum_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_sum_q   <= '0;
            out_full_q  <= 1'b0;
        end else if (bus.clr) begin
            for (int i = 0; i < CH; i++)
                sum_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_sum_q   <= '0;
            out_full_q  <= 1'b0;
        end else begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                sum_q[s1_ch] <= sum_nx;
                out_ch_q     <= s1_ch;
                out_sum_q    <= sum_nx;
                out_full_q   <= s1_full;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_full  = out_full_q;

endmodule
